skip_seq_checker: RTL and testbench

Receive-side checker for the mod-1000 skip-counter sequence (0..500, 601..999, 0, ...). It samples a counter value stream qualified by a valid strobe, acquires lock to the sequence, and flags every out-of-sequence or illegal sample. It converts each legal value to a gap-free 0..899 index and counts errors. It sits downstream of any skip-counter source, such as a link or bus carrying the count, as its monitor/decoder.

---
 rtl/skip_seq_checker.sv | 198 +++++++++++++++++++
 tb/tb_skip_seq_checker.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/skip_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : skip_seq_checker
// Brief    : Receive-side lock/check monitor for a skip-counter sequence
//            (0..SKIP_LO-1, SKIP_HI+1..MAX_VAL, wrap to 0). It flags
//            out-of-sequence and illegal samples, converts legal values to a
//            gap-free index and keeps a saturating error count.
// Revision : 1.0 - initial release
// ============================================================================
module skip_seq_checker #(
  parameter int W       = 10,
  parameter int SKIP_LO = 501,
  parameter int SKIP_HI = 600,
  parameter int MAX_VAL = 999,
  parameter int LOCK_N  = 3,
  parameter int MISS_N  = 4,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,       // asynchronous, active-low
  input  logic             in_vld,
  input  logic [W-1:0]     in_cnt,
  output logic             locked,
  output logic [W-1:0]     exp_cnt,
  output logic             err_pulse,
  output logic             illegal_pulse,
  output logic             wrap_pulse,
  output logic [W-1:0]     idx,
  output logic             idx_vld,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [1:0] c_st_hunt   = 2'd0;
  localparam logic [1:0] c_st_verify = 2'd1;
  localparam logic [1:0] c_st_locked = 2'd2;

  localparam logic [W-1:0] c_skip_lo    = W'(SKIP_LO);
  localparam logic [W-1:0] c_skip_hi    = W'(SKIP_HI);
  localparam logic [W-1:0] c_max_val    = W'(MAX_VAL);
  localparam logic [W-1:0] c_pre_skip   = W'(SKIP_LO - 1);
  localparam logic [W-1:0] c_post_skip  = W'(SKIP_HI + 1);
  localparam logic [W-1:0] c_skip_span  = W'(SKIP_HI - SKIP_LO + 1);
  localparam logic [3:0]   c_lock_n     = 4'(LOCK_N);
  localparam logic [3:0]   c_miss_n     = 4'(MISS_N);

  function automatic logic is_legal(input logic [W-1:0] v);
    return (v <= c_max_val) && !((v >= c_skip_lo) && (v <= c_skip_hi));
  endfunction

  function automatic logic [W-1:0] seq_next(input logic [W-1:0] v);
    if (v == c_max_val)       return '0;
    else if (v == c_pre_skip) return c_post_skip;
    else                      return v + W'(1);
  endfunction

  function automatic logic [W-1:0] compact(input logic [W-1:0] v);
    return (v < c_skip_lo) ? v : (v - c_skip_span);
  endfunction

  logic [1:0]       r_state, w_state_nxt;
  logic [3:0]       r_match_cnt, w_match_nxt;
  logic [3:0]       r_miss_cnt, w_miss_nxt;
  logic [W-1:0]     r_exp_cnt, w_exp_nxt;
  logic [W-1:0]     r_idx, w_idx_nxt;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;
  logic             r_idx_vld, w_idx_vld;
  logic             r_err_pulse, w_err_pulse;
  logic             r_ill_pulse, w_ill_pulse;
  logic             r_wrap_pulse, w_wrap_pulse;

  logic w_in_legal;
  logic w_in_match;

  assign w_in_legal = is_legal(in_cnt);
  assign w_in_match = (in_cnt == r_exp_cnt);

  // State, counters and registered outputs; everything clears asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= c_st_hunt;
      r_match_cnt  <= '0;
      r_miss_cnt   <= '0;
      r_exp_cnt    <= '0;
      r_idx        <= '0;
      r_err_cnt    <= '0;
      r_idx_vld    <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_ill_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_match_cnt  <= w_match_nxt;
      r_miss_cnt   <= w_miss_nxt;
      r_exp_cnt    <= w_exp_nxt;
      r_idx        <= w_idx_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_idx_vld    <= w_idx_vld;
      r_err_pulse  <= w_err_pulse;
      r_ill_pulse  <= w_ill_pulse;
      r_wrap_pulse <= w_wrap_pulse;
    end
  end

  // Lock acquisition / loss, expected-value tracking (flywheel while locked).
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_exp_nxt   = r_exp_cnt;
    if (in_vld) begin
      case (r_state)
        c_st_hunt: begin
          if (w_in_legal) begin
            w_exp_nxt   = seq_next(in_cnt);
            w_match_nxt = 4'd1;
            w_miss_nxt  = '0;
            w_state_nxt = (c_lock_n == 4'd1) ? c_st_locked : c_st_verify;
          end
        end
        c_st_verify: begin
          if (w_in_match) begin
            w_match_nxt = r_match_cnt + 4'd1;
            w_exp_nxt   = seq_next(in_cnt);
            if ((r_match_cnt + 4'd1) == c_lock_n) begin
              w_state_nxt = c_st_locked;
              w_miss_nxt  = '0;
            end
          end else if (w_in_legal) begin
            // Any legal value is a fresh candidate start of the sequence.
            w_exp_nxt   = seq_next(in_cnt);
            w_match_nxt = 4'd1;
            w_state_nxt = (c_lock_n == 4'd1) ? c_st_locked : c_st_verify;
          end else begin
            w_match_nxt = '0;
            w_state_nxt = c_st_hunt;
          end
        end
        c_st_locked: begin
          if (w_in_match) begin
            w_miss_nxt = '0;
            w_exp_nxt  = seq_next(in_cnt);
          end else begin
            // Keep advancing on our own so one bad sample costs one error.
            w_exp_nxt = seq_next(r_exp_cnt);
            if ((r_miss_cnt + 4'd1) == c_miss_n) begin
              w_state_nxt = c_st_hunt;
              w_miss_nxt  = '0;
              w_match_nxt = '0;
            end else begin
              w_miss_nxt = r_miss_cnt + 4'd1;
            end
          end
        end
        default: begin
          w_state_nxt = c_st_hunt;
          w_match_nxt = '0;
          w_miss_nxt  = '0;
        end
      endcase
    end
  end

  // Per-sample pulses, compact index and saturating error count.
  always_comb begin
    w_idx_vld     = 1'b0;
    w_err_pulse   = 1'b0;
    w_ill_pulse   = 1'b0;
    w_wrap_pulse  = 1'b0;
    w_idx_nxt     = r_idx;
    w_err_cnt_nxt = r_err_cnt;
    if (in_vld) begin
      w_ill_pulse = !w_in_legal;
      if (w_in_legal) begin
        w_idx_vld = 1'b1;
        w_idx_nxt = compact(in_cnt);
      end
      if (r_state == c_st_locked) begin
        if (w_in_match) begin
          w_wrap_pulse = (in_cnt == '0);
        end else begin
          w_err_pulse = 1'b1;
          if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
        end
      end
    end
  end

  assign locked        = (r_state == c_st_locked);
  assign exp_cnt       = r_exp_cnt;
  assign idx           = r_idx;
  assign idx_vld       = r_idx_vld;
  assign err_cnt       = r_err_cnt;
  assign err_pulse     = r_err_pulse;
  assign illegal_pulse = r_ill_pulse;
  assign wrap_pulse    = r_wrap_pulse;

endmodule
`default_nettype wire

// File: tb/tb_skip_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_skip_seq_checker
// Brief    : Directed self-checking bench for skip_seq_checker. A second
//            instance with a 2-bit error counter sees the same stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skip_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic [9:0] in_cnt;

  logic       locked, err_pulse, illegal_pulse, wrap_pulse, idx_vld;
  logic [9:0] exp_cnt, idx;
  logic [7:0] err_cnt;

  logic       locked2, err_pulse2, illegal_pulse2, wrap_pulse2, idx_vld2;
  logic [9:0] exp_cnt2, idx2;
  logic [1:0] err_cnt2;

  int npass  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  skip_seq_checker dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_cnt(in_cnt),
    .locked(locked), .exp_cnt(exp_cnt), .err_pulse(err_pulse),
    .illegal_pulse(illegal_pulse), .wrap_pulse(wrap_pulse),
    .idx(idx), .idx_vld(idx_vld), .err_cnt(err_cnt)
  );

  skip_seq_checker #(.ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_cnt(in_cnt),
    .locked(locked2), .exp_cnt(exp_cnt2), .err_pulse(err_pulse2),
    .illegal_pulse(illegal_pulse2), .wrap_pulse(wrap_pulse2),
    .idx(idx2), .idx_vld(idx_vld2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntotal++;
    assert (obs === expv) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Present one sample, let the DUT take it, then sample outputs 1 ns later.
  task automatic step(input logic v, input logic [9:0] c);
    in_vld = v;
    in_cnt = c;
    @(posedge clk);
    #1;
  endtask

  // Check the three pulse outputs at once.
  task automatic chk_pulses(input string tag, input logic e, input logic il, input logic wr);
    chk({tag, "_err"}, err_pulse, e);
    chk({tag, "_ill"}, illegal_pulse, il);
    chk({tag, "_wrap"}, wrap_pulse, wr);
  endtask

  initial begin
    rst = 1'b0; in_vld = 1'b0; in_cnt = '0;
    #2;
    chk("rst_locked", locked, 0);
    chk("rst_exp", exp_cnt, 0);
    chk("rst_idx", idx, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_idxvld", idx_vld, 0);
    chk_pulses("rst", 0, 0, 0);
    #1 rst = 1'b1;

    // Acquire lock on 0,1,2
    step(1, 0);
    chk("acq0_locked", locked, 0); chk("acq0_idx", idx, 0); chk("acq0_idxvld", idx_vld, 1);
    chk("acq0_exp", exp_cnt, 1);
    step(1, 1);
    chk("acq1_locked", locked, 0); chk("acq1_idx", idx, 1);
    step(1, 2);
    chk("acq2_locked", locked, 1); chk("acq2_exp", exp_cnt, 3);
    chk("acq2_idx", idx, 2); chk("acq2_errcnt", err_cnt, 0);
    chk_pulses("acq2", 0, 0, 0);

    // Cross the skipped window
    for (int v = 3; v <= 498; v++) step(1, 10'(v));
    step(1, 499); chk("s499_idx", idx, 499); chk_pulses("s499", 0, 0, 0);
    step(1, 500); chk("s500_idx", idx, 500); chk("s500_exp", exp_cnt, 601);
    step(1, 601); chk("s601_idx", idx, 501); chk_pulses("s601", 0, 0, 0);
    step(1, 602); chk("s602_idx", idx, 502); chk("s602_locked", locked, 1);

    // Wrap at MAX_VAL
    for (int v = 603; v <= 997; v++) step(1, 10'(v));
    step(1, 998); chk("s998_idx", idx, 898);
    step(1, 999); chk("s999_idx", idx, 899); chk("s999_wrap", wrap_pulse, 0);
    chk("s999_exp", exp_cnt, 0);
    step(1, 0);   chk("w0_idx", idx, 0); chk_pulses("w0", 0, 0, 1); chk("w0_exp", exp_cnt, 1);
    step(1, 1);   chk("w1_wrap", wrap_pulse, 0);

    // Illegal sample while locked at exp_cnt=100
    for (int v = 2; v <= 99; v++) step(1, 10'(v));
    chk("pre_ill_exp", exp_cnt, 100);
    step(1, 550);
    chk_pulses("ill", 1, 1, 0);
    chk("ill_idx", idx, 99); chk("ill_idxvld", idx_vld, 0);
    chk("ill_exp", exp_cnt, 101); chk("ill_errcnt", err_cnt, 1); chk("ill_locked", locked, 1);
    step(1, 101);
    chk_pulses("res", 0, 0, 0);
    chk("res_locked", locked, 1); chk("res_errcnt", err_cnt, 1); chk("res_idx", idx, 101);

    // Gaps hold state, no pulses
    step(0, 555);
    chk_pulses("gap", 0, 0, 0); chk("gap_idxvld", idx_vld, 0);
    chk("gap_exp", exp_cnt, 102); chk("gap_idx", idx, 101);
    step(0, 7);
    chk("gap2_locked", locked, 1); chk("gap2_exp", exp_cnt, 102); chk("gap2_errcnt", err_cnt, 1);

    // Four consecutive wrong legal values drop lock
    for (int v = 102; v <= 199; v++) step(1, 10'(v));
    chk("pre_miss_exp", exp_cnt, 200);
    step(1, 10); chk("m1_err", err_pulse, 1); chk("m1_locked", locked, 1);
    chk("m1_idx", idx, 10); chk("m1_exp", exp_cnt, 201); chk("m1_errcnt", err_cnt, 2);
    step(1, 10); chk("m2_err", err_pulse, 1); chk("m2_locked", locked, 1);
    step(1, 10); chk("m3_err", err_pulse, 1); chk("m3_locked", locked, 1);
    chk("m3_errcnt2", err_cnt2, 3);
    step(1, 10); chk("m4_err", err_pulse, 1); chk("m4_locked", locked, 0);
    chk("m4_errcnt", err_cnt, 5); chk("m4_exp", exp_cnt, 204);
    chk("sat_errcnt2", err_cnt2, 3); chk("m4_ill", illegal_pulse, 0);

    // Relock on 10,11,12 with no new errors
    step(1, 10); chk("rl0_err", err_pulse, 0); chk("rl0_locked", locked, 0); chk("rl0_exp", exp_cnt, 11);
    step(1, 11); chk("rl1_locked", locked, 0);
    step(1, 12); chk("rl2_locked", locked, 1); chk("rl2_exp", exp_cnt, 13);
    chk("rl2_errcnt", err_cnt, 5); chk("rl2_errcnt2", err_cnt2, 3);

    // Asynchronous reset mid-lock, observed before any clock edge
    in_vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_locked", locked, 0); chk("arst_errcnt", err_cnt, 0);
    chk("arst_exp", exp_cnt, 0); chk("arst_idx", idx, 0); chk("arst_errcnt2", err_cnt2, 0);
    #3 rst = 1'b1;

    // Out-of-range value in HUNT: illegal only, idx holds
    step(1, 1023);
    chk_pulses("hunt_ill", 0, 1, 0); chk("hunt_ill_idx", idx, 0);
    chk("hunt_ill_idxvld", idx_vld, 0); chk("hunt_ill_errcnt", err_cnt, 0);

    // Reacquire from HUNT
    step(1, 5); chk("ra0_locked", locked, 0);
    step(1, 6); chk("ra1_locked", locked, 0);
    step(1, 7); chk("ra2_locked", locked, 1); chk("ra2_exp", exp_cnt, 8); chk("ra2_idx", idx, 7);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire
